// File: rtl/instr_fetch_unpacker.sv
// Buffers wide instruction-memory read words in a small FIFO and hands them to
// the decoder one instruction per handshake, least-significant slice first.
module instr_fetch_unpacker #(
  parameter int MEM_WORD_W = 256,
  parameter int INSTR_W    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic                            instr_vld,
  input  logic [MEM_WORD_W-1:0]           mem_rd_data,
  output logic                            fetcher_rdy,
  output logic [INSTR_W-1:0]              instr_out,
  output logic                            instr_out_vld,
  input  logic                            instr_out_rdy,
  output logic [$clog2(FIFO_DEPTH):0]     word_cnt
);

  localparam int INSTR_PER_WORD = MEM_WORD_W / INSTR_W;
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNT_W          = PTR_W + 1;
  localparam int IDX_W          = (INSTR_PER_WORD > 1) ? $clog2(INSTR_PER_WORD) : 1;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(INSTR_PER_WORD - 1);

  if ((MEM_WORD_W % INSTR_W) != 0 || INSTR_PER_WORD < 2) begin : g_bad_width
    $fatal(1, "MEM_WORD_W must be a multiple (>=2x) of INSTR_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "FIFO_DEPTH must be a power of two >= 2");
  end

  logic [MEM_WORD_W-1:0] word_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, wr_ptr_nxt;
  logic [PTR_W-1:0]      rd_ptr, rd_ptr_nxt;
  logic [CNT_W-1:0]      count, count_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;

  logic                  full;
  logic                  push;
  logic                  pop;
  logic                  word_done;
  logic [MEM_WORD_W-1:0] head_word;

  // Ready is derived only from registered occupancy plus rst/flush, so the
  // upstream pipeline never sees a combinational loop through this block.
  assign full        = (count == CNT_FULL);
  assign fetcher_rdy = !rst && !flush && !full;
  assign push        = instr_vld && fetcher_rdy;

  assign instr_out_vld = (count != '0);
  assign pop           = instr_out_vld && instr_out_rdy;
  assign word_done     = pop && (idx == IDX_LAST);

  assign head_word = word_mem[rd_ptr];
  assign instr_out = head_word[int'(idx)*INSTR_W +: INSTR_W];
  assign word_cnt  = count;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = count;
    idx_nxt    = idx;
    if (flush) begin
      wr_ptr_nxt = '0;
      rd_ptr_nxt = '0;
      count_nxt  = '0;
      idx_nxt    = '0;
    end else begin
      if (push) begin
        wr_ptr_nxt = wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        idx_nxt = word_done ? '0 : idx + IDX_W'(1);
      end
      if (word_done) begin
        rd_ptr_nxt = rd_ptr + PTR_W'(1);
      end
      case ({push, word_done})
        2'b10:   count_nxt = count + CNT_W'(1);
        2'b01:   count_nxt = count - CNT_W'(1);
        default: count_nxt = count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      idx    <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      count  <= count_nxt;
      idx    <= idx_nxt;
    end
  end

  // Word storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      word_mem[wr_ptr] <= mem_rd_data;
    end
  end

  always @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full))
        else $error("instr_fetch_unpacker: push while FIFO full");
    end
  end

endmodule

// File: tb/tb_instr_fetch_unpacker.sv
// Directed bench for instr_fetch_unpacker: a queue of expected instructions is
// filled on every accepted word and drained on every decoder handshake.
module tb_instr_fetch_unpacker;

  localparam int MW  = 256;
  localparam int IW  = 32;
  localparam int D   = 4;
  localparam int IPW = MW / IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          instr_vld;
  logic [MW-1:0] mem_rd_data;
  logic          fetcher_rdy;
  logic [IW-1:0] instr_out;
  logic          instr_out_vld;
  logic          instr_out_rdy;
  logic [2:0]    word_cnt;

  int            checks = 0;
  int            errors = 0;
  logic [IW-1:0] sb[$];
  int            m_cnt = 0;
  int            m_idx = 0;
  bit            stream_done;

  always #5 clk = ~clk;

  instr_fetch_unpacker #(.MEM_WORD_W(MW), .INSTR_W(IW), .FIFO_DEPTH(D)) dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .instr_vld     (instr_vld),
    .mem_rd_data   (mem_rd_data),
    .fetcher_rdy   (fetcher_rdy),
    .instr_out     (instr_out),
    .instr_out_vld (instr_out_vld),
    .instr_out_rdy (instr_out_rdy),
    .word_cnt      (word_cnt)
  );

  function automatic logic [MW-1:0] mk_word(input logic [IW-1:0] base);
    logic [MW-1:0] w;
    for (int k = 0; k < IPW; k++) w[k*IW +: IW] = base + IW'(k);
    return w;
  endfunction

  // Mid-cycle monitor: reference occupancy model plus instruction scoreboard.
  always @(negedge clk) begin : monitor
    logic          exp_rdy, exp_vld, do_pop, do_push, do_rel;
    logic [IW-1:0] exp_instr;
    exp_rdy = !rst && !flush && (m_cnt != D);
    exp_vld = (m_cnt != 0);
    checks++;
    assert (fetcher_rdy === exp_rdy) else begin
      errors++; $error("FAIL fetcher_rdy observed=%0b expected=%0b t=%0t", fetcher_rdy, exp_rdy, $time);
    end
    checks++;
    assert (instr_out_vld === exp_vld) else begin
      errors++; $error("FAIL instr_out_vld observed=%0b expected=%0b t=%0t", instr_out_vld, exp_vld, $time);
    end
    checks++;
    assert (word_cnt === 3'(m_cnt)) else begin
      errors++; $error("FAIL word_cnt observed=%0d expected=%0d t=%0t", word_cnt, m_cnt, $time);
    end
    do_pop  = exp_vld && instr_out_rdy;
    do_push = exp_rdy && instr_vld;
    do_rel  = do_pop && (m_idx == IPW - 1);
    if (do_pop) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++; $error("FAIL sb_underflow observed=%h expected=<empty queue> t=%0t", instr_out, $time);
      end
      if (sb.size() != 0) begin
        exp_instr = sb.pop_front();
        checks++;
        assert (instr_out === exp_instr) else begin
          errors++; $error("FAIL instr_out observed=%h expected=%h t=%0t", instr_out, exp_instr, $time);
        end
      end
    end
    if (do_push) begin
      for (int k = 0; k < IPW; k++) sb.push_back(mem_rd_data[k*IW +: IW]);
    end
    if (rst || flush) begin
      m_cnt = 0;
      m_idx = 0;
      sb.delete();
    end else begin
      if (do_pop) m_idx = do_rel ? 0 : m_idx + 1;
      m_cnt = m_cnt + int'(do_push) - int'(do_rel);
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic wait_accept();
    int n = 0;
    #1;
    while (!fetcher_rdy && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    checks++;
    assert (n < 200) else begin
      errors++; $error("FAIL accept_timeout observed=%0d expected=<200 cycles", n);
    end
    @(posedge clk); #1;
    instr_vld   = 1'b0;
    mem_rd_data = '0;
  endtask

  task automatic send_word(input logic [MW-1:0] w);
    instr_vld   = 1'b1;
    mem_rd_data = w;
    wait_accept();
  endtask

  task automatic drain();
    int n = 0;
    instr_out_rdy = 1'b1;
    while (m_cnt != 0 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    assert (n < 500) else begin
      errors++; $error("FAIL drain_timeout observed=%0d expected=<500 cycles", n);
    end
  endtask

  task automatic check_idle(input string tag);
    checks++;
    assert (word_cnt === 3'd0 && instr_out_vld === 1'b0 && fetcher_rdy === 1'b1) else begin
      errors++;
      $error("FAIL %s observed=cnt%0d/vld%0b/rdy%0b expected=cnt0/vld0/rdy1", tag, word_cnt, instr_out_vld, fetcher_rdy);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; instr_vld = 1'b0; instr_out_rdy = 1'b0; mem_rd_data = '0;
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    #1; check_idle("after_reset");

    // Single word, instruction k = k, decoder always ready.
    @(posedge clk); #1;
    instr_out_rdy = 1'b1;
    send_word(mk_word(32'd0));
    drain();
    check_idle("single_word_done");

    // Fill all slots with the decoder stalled, then hold a fifth word.
    instr_out_rdy = 1'b0;
    for (int n = 1; n <= D; n++) send_word(mk_word(32'h0001_0000 * n));
    checks++;
    assert (word_cnt === 3'd4 && fetcher_rdy === 1'b0) else begin
      errors++; $error("FAIL full_state observed=cnt%0d/rdy%0b expected=cnt4/rdy0", word_cnt, fetcher_rdy);
    end
    instr_vld   = 1'b1;
    mem_rd_data = mk_word(32'h0005_0000);
    repeat (10) @(posedge clk);
    #1;
    checks++;
    assert (word_cnt === 3'd4) else begin
      errors++; $error("FAIL held_word_count observed=%0d expected=4", word_cnt);
    end
    instr_out_rdy = 1'b1;
    wait_accept();
    drain();

    // Back-to-back stream of 16 words with the decoder ready every other cycle.
    instr_out_rdy = 1'b0;
    stream_done   = 1'b0;
    fork
      begin
        for (int n = 0; n < 16; n++) send_word(mk_word(32'h0100_0000 + 32'(n) * 32'h100));
        stream_done = 1'b1;
      end
      begin
        int c = 0;
        while (!stream_done && c < 3000) begin
          @(posedge clk); #1;
          instr_out_rdy = ~instr_out_rdy;
          c++;
        end
      end
    join
    drain();

    // Flush with 3 words buffered and sub-index 5.
    instr_out_rdy = 1'b0;
    for (int n = 0; n < 3; n++) send_word(mk_word(32'h0200_0000 + 32'(n) * 32'h100));
    instr_out_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1; instr_out_rdy = 1'b0;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1; check_idle("after_flush");
    instr_out_rdy = 1'b1;
    send_word(mk_word(32'h0300_0000));
    drain();

    // Reset mid-stream with 2 words buffered and sub-index 3.
    instr_out_rdy = 1'b0;
    for (int n = 0; n < 2; n++) send_word(mk_word(32'h0400_0000 + 32'(n) * 32'h100));
    instr_out_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1; instr_out_rdy = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    #1; check_idle("after_mid_reset");
    instr_out_rdy = 1'b1;
    send_word(mk_word(32'h0500_0000));
    drain();

    // Flush and reset together behave like reset alone.
    instr_out_rdy = 1'b0;
    send_word(mk_word(32'h0600_0000));
    rst = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; flush = 1'b0;
    #1; check_idle("after_rst_flush");
    instr_out_rdy = 1'b1;
    send_word(mk_word(32'h0700_0000));
    drain();

    @(posedge clk); #1;
    checks++;
    assert (sb.size() == 0) else begin
      errors++; $error("FAIL leftover_expected observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
